// File: rtl/clk_div_multi.sv
// clk_div_multi -- bank of independent programmable clock dividers.
//
// Each channel divides clk_i by 2*H, where H is a per-channel half-period in
// clk_i cycles. H is double-buffered: software writes a shadow copy, and the
// running counter only picks it up at a half-period boundary. This keeps
// clk_o free of glitches when H changes. Writing H=0 stops the channel at
// the end of its current half, and it then parks high.
//
// Optional feature: define CLK_DIV_TICK_EN to add tick_o. tick_o is a
// one-cycle pulse per channel, high during the cycle that follows each
// counter-driven clk_o inversion.
//
// Parameters
//   NUM_CH      number of channels (1..16)
//   CNT_W       counter / half-period width (2..32)
//   RESET_HALF  half-period loaded into shadow and active by reset
//
// Ports
//   clk_i       system clock; all logic runs on its rising edge
//   rst_ni      asynchronous active-low reset
//   en_i        per-channel run enable
//   sync_i      one-cycle pulse that restarts all running channels in phase
//   wr_en_i     half-period write strobe
//   wr_ch_i     channel index for the write (indices >= NUM_CH are ignored)
//   wr_half_i   new half-period H
//   clk_o       divided clocks, registered
//   tick_o      per-channel toggle pulse (CLK_DIV_TICK_EN builds only)
module clk_div_multi #(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter int unsigned RESET_HALF = 50_000_000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_i,
  input  logic              wr_en_i,
  input  logic [3:0]        wr_ch_i,
  input  logic [CNT_W-1:0]  wr_half_i,
  output logic [NUM_CH-1:0] clk_o
`ifdef CLK_DIV_TICK_EN
  ,
  output logic [NUM_CH-1:0] tick_o
`endif
);

  localparam logic [CNT_W-1:0] RST_H = CNT_W'(RESET_HALF);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO  = '0;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    state_t           state, state_nx;
    logic [CNT_W-1:0] shadow, shadow_nx;
    logic [CNT_W-1:0] active, active_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             clk_q, clk_nx;
    logic             wr_hit;
    logic             terminal;

    // The 4-bit compare never matches an index >= NUM_CH, so those writes
    // fall through without touching any channel.
    assign wr_hit   = wr_en_i && (wr_ch_i == 4'(n));
    // active is never 0 while running: a zero shadow sends the channel to
    // STOP instead of being loaded into a running counter.
    assign terminal = (cnt == active - ONE);

    always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      active_nx = active;
      clk_nx    = clk_q;
      // This cycle's shadow (the pre-write value) feeds active. A write that
      // lands in a terminal cycle therefore only takes effect at the
      // following terminal.
      shadow_nx = wr_hit ? wr_half_i : shadow;
      case (state)
        ST_STOP: begin
          cnt_nx    = ZERO;
          clk_nx    = 1'b1;
          active_nx = shadow;
          if (en_i[n] && (shadow != ZERO)) state_nx = ST_RUN;
        end
        default: begin
          if (!en_i[n]) begin
            state_nx  = ST_STOP;
            cnt_nx    = ZERO;
            clk_nx    = 1'b1;
            active_nx = shadow;
          end else if (sync_i) begin
            // A restart overrides a coinciding terminal. It always lands on
            // the high level and does not count as a toggle.
            cnt_nx    = ZERO;
            clk_nx    = 1'b1;
            active_nx = shadow;
            if (shadow == ZERO) state_nx = ST_STOP;
          end else if (terminal) begin
            cnt_nx    = ZERO;
            active_nx = shadow;
            if (shadow == ZERO) begin
              state_nx = ST_STOP;
              clk_nx   = 1'b1;
            end else begin
              clk_nx   = ~clk_q;
            end
          end else begin
            cnt_nx = cnt + ONE;
          end
        end
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state  <= ST_STOP;
        shadow <= RST_H;
        active <= RST_H;
        cnt    <= ZERO;
        clk_q  <= 1'b1;
      end else begin
        state  <= state_nx;
        shadow <= shadow_nx;
        active <= active_nx;
        cnt    <= cnt_nx;
        clk_q  <= clk_nx;
      end
    end

    assign clk_o[n] = clk_q;

`ifdef CLK_DIV_TICK_EN
    logic tick_q, tick_nx;

    // Only a counter-driven inversion produces a tick. A forced high level
    // caused by sync, an enable drop, or STOP never does.
    assign tick_nx = (state == ST_RUN) && en_i[n] && !sync_i && terminal &&
                     (clk_nx != clk_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) tick_q <= 1'b0;
      else         tick_q <= tick_nx;
    end

    assign tick_o[n] = tick_q;
`endif
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (NUM_CH=4, CNT_W=8, RESET_HALF=4).
// Each scenario records clk_o after every rising edge, then compares the
// waveform of a channel against a hand-computed bit pattern. The first
// sample is the MSB of the pattern.
module tb_clk_div_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NUM_CH-1:0] en_i = '0;
  logic              sync_i = 1'b0;
  logic              wr_en_i = 1'b0;
  logic [3:0]        wr_ch_i = '0;
  logic [CNT_W-1:0]  wr_half_i = '0;
  logic [NUM_CH-1:0] clk_o;
`ifdef CLK_DIV_TICK_EN
  logic [NUM_CH-1:0] tick_o;
`endif

  int nchk = 0;
  int nbad = 0;
  int tick_err = 0;
  logic [NUM_CH-1:0] smp [64];

  always #5 clk_i = ~clk_i;

  clk_div_multi #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .RESET_HALF (4)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .sync_i    (sync_i),
    .wr_en_i   (wr_en_i),
    .wr_ch_i   (wr_ch_i),
    .wr_half_i (wr_half_i),
    .clk_o     (clk_o)
`ifdef CLK_DIV_TICK_EN
    ,
    .tick_o    (tick_o)
`endif
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Runs n rising edges and records clk_o after each one. A caller may
  // preset sync_i; it is dropped after the first edge. When wr_at >= 0,
  // a write is presented after sample wr_at, so it lands on edge wr_at+1.
  task automatic run_cap(int n, int wr_at, logic [3:0] wch, logic [CNT_W-1:0] wh);
`ifdef CLK_DIV_TICK_EN
    logic [NUM_CH-1:0] prev = '1;
`endif
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
      smp[i] = clk_o;
`ifdef CLK_DIV_TICK_EN
      if (i > 0 && tick_o !== (clk_o ^ prev)) tick_err++;
      prev = clk_o;
`endif
      sync_i  = 1'b0;
      wr_en_i = 1'b0;
      if (i == wr_at) begin
        wr_en_i   = 1'b1;
        wr_ch_i   = wch;
        wr_half_i = wh;
      end
    end
  endtask

  function automatic logic [31:0] pick(int ch, int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], smp[i][ch]};
    return v;
  endfunction

  task automatic wr(logic [3:0] ch, logic [CNT_W-1:0] h);
    wr_en_i   = 1'b1;
    wr_ch_i   = ch;
    wr_half_i = h;
    @(posedge clk_i);
    #1;
    wr_en_i = 1'b0;
  endtask

  initial begin
    // Reset state, then H=4 on ch0: 4 high, 4 low.
    en_i = 4'b0001;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_clk", 32'(clk_o), 32'hF);
`ifdef CLK_DIV_TICK_EN
    chk("rst_tick", 32'(tick_o), 32'h0);
`endif
    rst_ni = 1'b1;
    run_cap(16, -1, 4'd0, '0);
    chk("t1_ch0", pick(0, 16), 32'hF0F0);
    chk("t1_idle", 32'(smp[15][3:1]), 32'h7);

    // ch1 starts with H=4; H=2 is written mid high-half.
    en_i = 4'b0011;
    run_cap(12, 1, 4'd1, 8'd2);
    chk("t2_ch1", pick(1, 12), 32'hF33);

    // Sync, then write H=3 exactly in ch1's terminal cycle.
    sync_i = 1'b1;
    run_cap(12, 1, 4'd1, 8'd3);
    chk("t3_ch1", pick(1, 12), 32'hCE3);

    // ch0 H=3, ch1 H=5, then sync: first falls at 3 and 5 cycles.
    wr(4'd0, 8'd3);
    wr(4'd1, 8'd5);
    sync_i = 1'b1;
    run_cap(12, -1, 4'd0, '0);
    chk("t4_ch0", pick(0, 12), 32'hE38);
    chk("t4_ch1", pick(1, 12), 32'hF83);

    // ch2 runs with H=4; H=0 is written in its low half, so it parks high.
    en_i   = 4'b0111;
    sync_i = 1'b1;
    run_cap(16, 5, 4'd2, 8'd0);
    chk("t5_ch2", pick(2, 16), 32'hF0FF);

    // A write to channel 15 must not alter any channel.
    wr(4'd15, 8'd1);
    en_i   = 4'b1111;
    sync_i = 1'b1;
    run_cap(12, -1, 4'd0, '0);
    chk("t5b_ch0", pick(0, 12), 32'hE38);
    chk("t5b_ch1", pick(1, 12), 32'hF83);
    chk("t5b_ch2", pick(2, 12), 32'hFFF);
    chk("t5b_ch3", pick(3, 12), 32'hF0F);

    // Asynchronous reset while ch0 is low.
    chk("t6_pre", 32'(clk_o[0]), 32'h0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_async", 32'(clk_o), 32'hF);
`ifdef CLK_DIV_TICK_EN
    chk("t6_tick", 32'(tick_o), 32'h0);
`endif
    en_i = 4'b0001;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    run_cap(8, -1, 4'd0, '0);
    chk("t6_after", pick(0, 8), 32'hF0);
`ifdef CLK_DIV_TICK_EN
    chk("tick_vs_toggle", 32'(tick_err), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent divider channels (legal 1..16).
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the counter and half-period width (legal 2..32).
REQ-003 The block SHALL have parameter RESET_HALF, default 50_000_000, giving the half-period loaded at reset (nonzero, < 2^CNT_W).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port en_i, input, NUM_CH bits: per-channel run enable.
REQ-007 The block SHALL have port sync_i, input, 1 bit: one-cycle pulse that restarts all channels phase-aligned.
REQ-008 The block SHALL have port wr_en_i, input, 1 bit: half-period write strobe.
REQ-009 The block SHALL have port wr_ch_i, input, 4 bits: channel index for the write.
REQ-010 The block SHALL have port wr_half_i, input, CNT_W bits: new half-period H in clk_i cycles.
REQ-011 The block SHALL have port clk_o, output, NUM_CH bits: divided clock per channel, registered.
REQ-012 The block SHALL have port tick_o, output, NUM_CH bits: one-cycle pulse on each clk_o toggle (present only per REQ-027).

Function
REQ-013 Each channel SHALL hold a shadow half-period (written by software), an active half-period, a counter cnt, and state STOP or RUN.
REQ-014 In RUN, cnt SHALL increment by 1 each cycle; when cnt == active-1 (terminal), the channel SHALL set cnt to 0, invert clk_o, and load active from shadow in the same cycle.
REQ-015 The output period SHALL be 2*H cycles with 50% duty; H=1 SHALL give clk_i/2.
REQ-016 A write with wr_en_i=1 SHALL update the shadow of channel wr_ch_i in the next cycle; a write with wr_ch_i >= NUM_CH SHALL be ignored.
REQ-017 A write coinciding with that channel's terminal cycle SHALL NOT reach active at that terminal; it SHALL take effect at the following terminal.
REQ-018 STOP->RUN SHALL occur when en_i[n]=1 and shadow != 0; on entry, active SHALL equal shadow and cnt SHALL equal 0.
REQ-019 RUN->STOP SHALL occur on the cycle en_i[n] is sampled low, or at a terminal where shadow == 0.
REQ-020 In STOP, cnt SHALL be held at 0, clk_o[n] SHALL be 1, and active SHALL track shadow every cycle.
REQ-021 sync_i=1 SHALL force every RUN channel to cnt=0 and clk_o=1 and load active from pre-write shadow; sync SHALL take priority over terminal in that cycle, and no tick SHALL be emitted for the forced level.
REQ-022 Counter arithmetic SHALL be CNT_W bits unsigned, with no wrap beyond active-1.

Reset
REQ-023 While rst_ni=0, clk_o SHALL be all ones and tick_o all zeros.
REQ-024 While rst_ni=0, every cnt SHALL be 0, every shadow and active SHALL be RESET_HALF, and every channel SHALL be in STOP.
REQ-025 Reset assertion mid-period SHALL take effect immediately without waiting for a clock edge.
REQ-026 After rst_ni deasserts, channels with en_i=1 SHALL enter RUN on the first rising edge.

Configuration
REQ-027 With macro CLK_DIV_TICK_EN defined, tick_o SHALL exist and pulse high for exactly the cycle following each clk_o inversion caused by a terminal.
REQ-028 Without CLK_DIV_TICK_EN, port tick_o and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Bench: RESET_HALF=4, en_i=1 after reset -> clk_o[0] is high 4 cycles, low 4 cycles, period 8.
REQ-030 Bench: write H=2 to ch1 mid-period (H=4) -> current half stays 4 cycles, then halves are 2 cycles; clk_o has no glitch.
REQ-031 Bench: write H=3 in the exact terminal cycle -> next half is the old H; the half after that is 3.
REQ-032 Bench: ch0 H=3, ch1 H=5, pulse sync_i -> both go to 1, cnt=0, and their first falling edges are 3 and 5 cycles later.
REQ-033 Bench: write H=0 to ch2 while running -> ch2 stops at 1 after the current half; wr_ch_i=15 with NUM_CH=4 changes nothing.
REQ-034 Bench: assert rst_ni mid-count, and in a CLK_DIV_TICK_EN build count ticks -> outputs are 1 immediately; ticks equal toggles with one-cycle width.
